// File: rtl/dffram_wb_pkg.sv
// +----------------------------------------------------------------------------+
// | dffram_wb_pkg : shared state encoding and window compare for the adapter    |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

package dffram_wb_pkg;

  localparam int ADDR_LSB = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD1  = 3'd2,
    ST_RD2  = 3'd3,
    ST_ACK  = 3'd4,
    ST_ERR  = 3'd5
`ifdef DFFRAM_WB_PWRGATE_EN
    , ST_WAKE = 3'd6
`endif
  } state_t;

  // True when every address bit above the RAM word index matches the window base.
  function automatic logic in_window(input logic [31:0] adr,
                                     input logic [31:0] base,
                                     input int unsigned awidth);
    return (adr >> (awidth + ADDR_LSB)) == (base >> (awidth + ADDR_LSB));
  endfunction

endpackage

`default_nettype wire

// File: rtl/dffram_wb_pwrgate.sv
// +----------------------------------------------------------------------------+
// | dffram_wb_pwrgate : idle counter and gated flag controlling RAM EN0         |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module dffram_wb_pwrgate #(
  parameter int IDLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic req,
  input  logic hit,
  output logic gated,
  output logic gate_next
);

  localparam int            CW       = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(IDLE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // Error requests restart the count but do not wake the macro: no access follows.
  always_comb begin
    cnt_next  = cnt;
    gate_next = gated;
    if (idle) begin
      if (req) begin
        cnt_next = '0;
        if (hit) gate_next = 1'b0;
      end else if (!gated) begin
        if (cnt == CNT_LAST) gate_next = 1'b1;
        else                 cnt_next  = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      gated <= 1'b1;
    end else begin
      cnt   <= cnt_next;
      gated <= gate_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dffram_wb_adapter.sv
// +----------------------------------------------------------------------------+
// | dffram_wb_adapter : Wishbone B4 classic slave driving a DFFRAM512x32 port.  |
// | Optional EN0 idle gating with DFFRAM_WB_PWRGATE_EN.  Revision 1.0           |
// +----------------------------------------------------------------------------+
`default_nettype none

module dffram_wb_adapter
  import dffram_wb_pkg::*;
#(
  parameter int          BANKS       = 32,
  parameter int          WSIZE       = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          IDLE_CYCLES = 16,
  localparam int         AWIDTH      = $clog2(BANKS) + 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [WSIZE-1:0]     wb_sel_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [8*WSIZE-1:0]   wb_dat_i,
  output logic [8*WSIZE-1:0]   wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic [WSIZE-1:0]     ram_we0,
  output logic                 ram_en0,
  output logic [AWIDTH-1:0]    ram_a0,
  output logic [8*WSIZE-1:0]   ram_di0,
  input  logic [8*WSIZE-1:0]   ram_do0
);

  if (IDLE_CYCLES < 1) begin : g_cfg_check
    $error("dffram_wb_adapter: IDLE_CYCLES must be at least 1");
  end

  state_t            state;
  logic              req;
  logic              hit;
  logic [AWIDTH-1:0] word_adr;

  assign req      = wb_cyc_i & wb_stb_i;
  assign hit      = in_window(wb_adr_i, BASE_ADDR, AWIDTH);
  assign word_adr = wb_adr_i[AWIDTH+ADDR_LSB-1:ADDR_LSB];

`ifdef DFFRAM_WB_PWRGATE_EN
  logic             idle;
  logic             gated;
  logic             gate_next;
  logic             pend_we;
  logic [WSIZE-1:0] pend_sel;

  assign idle = (state == ST_IDLE);

  dffram_wb_pwrgate #(
    .IDLE_CYCLES(IDLE_CYCLES)
  ) u_pwrgate (
    .clk      (CLK),
    .rst      (RST),
    .idle     (idle),
    .req      (req),
    .hit      (hit),
    .gated    (gated),
    .gate_next(gate_next)
  );
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      ram_we0  <= '0;
      ram_en0  <= 1'b0;
      ram_a0   <= '0;
      ram_di0  <= '0;
`ifdef DFFRAM_WB_PWRGATE_EN
      pend_we  <= 1'b0;
      pend_sel <= '0;
`endif
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
`ifdef DFFRAM_WB_PWRGATE_EN
      ram_en0  <= !gate_next;
`else
      ram_en0  <= 1'b1;
`endif
      unique case (state)
        ST_IDLE: begin
          if (req && !hit) begin
            wb_err_o <= 1'b1;
            state    <= ST_ERR;
          end else if (req) begin
            ram_a0 <= word_adr;
            if (wb_we_i) ram_di0 <= wb_dat_i;
`ifdef DFFRAM_WB_PWRGATE_EN
            pend_we  <= wb_we_i;
            pend_sel <= wb_sel_i;
            // A gated macro gets one enabled, non-writing cycle before the access.
            if (gated) state <= ST_WAKE;
            else
`endif
            if (wb_we_i) begin
              ram_we0 <= wb_sel_i;
              state   <= ST_WR;
            end else begin
              ram_we0 <= '0;
              state   <= ST_RD1;
            end
          end
        end
`ifdef DFFRAM_WB_PWRGATE_EN
        ST_WAKE: begin
          if (!wb_cyc_i) begin
            state <= ST_IDLE;
          end else if (pend_we) begin
            ram_we0 <= pend_sel;
            state   <= ST_WR;
          end else begin
            state <= ST_RD1;
          end
        end
`endif
        ST_WR: begin
          ram_we0 <= '0;
          if (wb_cyc_i) begin
            wb_ack_o <= 1'b1;
            state    <= ST_ACK;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RD1: state <= wb_cyc_i ? ST_RD2 : ST_IDLE;
        ST_RD2: begin
          // Do0 reflects the address sampled at the end of RD1.
          if (wb_cyc_i) begin
            wb_dat_o <= ram_do0;
            wb_ack_o <= 1'b1;
            state    <= ST_ACK;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACK:  state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dffram_wb_adapter.sv
// +----------------------------------------------------------------------------+
// | tb_dffram_wb_adapter : directed + random bench with a word-level RAM model  |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dffram_wb_adapter;

`ifdef DFFRAM_WB_PWRGATE_EN
  localparam int GATED_BUILD = 1;
`else
  localparam int GATED_BUILD = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [3:0]  ram_we0;
  logic        ram_en0;
  logic [8:0]  ram_a0;
  logic [31:0] ram_di0;
  logic [31:0] ram_do0;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] ref_mem [512];
  logic [31:0] last_read = '0;
  int          wake_pending = GATED_BUILD;

  always #5 clk = ~clk;

  dffram_wb_adapter #(
    .BANKS(32), .WSIZE(4), .BASE_ADDR(32'h0), .IDLE_CYCLES(16)
  ) dut (
    .CLK(clk), .RST(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .ram_we0(ram_we0), .ram_en0(ram_en0), .ram_a0(ram_a0),
    .ram_di0(ram_di0), .ram_do0(ram_do0)
  );

  // DFFRAM512x32 port behaviour: byte writes and registered read when enabled.
  logic [31:0] ram [512];
  always @(posedge clk) begin
    if (ram_en0) begin
      for (int b = 0; b < 4; b++)
        if (ram_we0[b]) ram[ram_a0][8*b +: 8] <= ram_di0[8*b +: 8];
      ram_do0 <= ram[ram_a0];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_dat,
                     input logic [3:0] t_sel, output int ack_lat, output int err_lat,
                     output logic [31:0] rdata, output int we_cycles, output int en_changes);
    logic en_start;
    ack_lat = 0; err_lat = 0; rdata = '0; we_cycles = 0; en_changes = 0;
    @(posedge clk); #1;
    en_start = ram_en0;
    cyc = 1'b1; stb = 1'b1; we = t_we; adr = t_adr; dat = t_dat; sel = t_sel;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ram_we0 != 4'h0) we_cycles++;
      if (ram_en0 != en_start) en_changes++;
      if (wb_ack_o) begin ack_lat = k; rdata = wb_dat_o; end
      if (wb_err_o) err_lat = k;
      if (wb_ack_o || wb_err_o) break;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check("pulse_end", 32'({wb_ack_o, wb_err_o}), 32'd0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input string tag);
    int al, el, wc, ec, extra, w;
    logic [31:0] rd;
    extra = wake_pending; wake_pending = 0;
    txn(1'b1, a, d, s, al, el, rd, wc, ec);
    check({tag, "_lat"}, 32'(al), 32'(2 + extra));
    check({tag, "_noerr"}, 32'(el), 32'd0);
    check({tag, "_we_cyc"}, 32'(wc), (s != 4'h0) ? 32'd1 : 32'd0);
    check({tag, "_dat_hold"}, rd, last_read);
    w = int'((a >> 2) % 512);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic do_read(input logic [31:0] a, input string tag);
    int al, el, wc, ec, extra, w;
    logic [31:0] rd;
    extra = wake_pending; wake_pending = 0;
    txn(1'b0, a, 32'h0, 4'h0, al, el, rd, wc, ec);
    w = int'((a >> 2) % 512);
    check({tag, "_lat"}, 32'(al), 32'(3 + extra));
    check({tag, "_data"}, rd, ref_mem[w]);
    check({tag, "_we_cyc"}, 32'(wc), 32'd0);
    last_read = ref_mem[w];
  endtask

  task automatic do_bad(input logic [31:0] a, input logic t_we, input string tag);
    int al, el, wc, ec;
    logic [31:0] rd;
    txn(t_we, a, $urandom, 4'hF, al, el, rd, wc, ec);
    check({tag, "_err_lat"}, 32'(el), 32'd1);
    check({tag, "_noack"}, 32'(al), 32'd0);
    check({tag, "_ram_quiet"}, 32'(wc + ec), 32'd0);
  endtask

  function automatic logic [31:0] pick_addr(input int i);
    return 32'((i < 8) ? i * 4 : (500 + i) * 4);
  endfunction

  initial begin
    int          acks;
    logic [31:0] a;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(wb_ack_o), 32'd0);
    check("rst_err", 32'(wb_err_o), 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_we0", 32'(ram_we0), 32'd0);
    check("rst_en0", 32'(ram_en0), 32'd0);
    check("rst_a0",  32'(ram_a0), 32'd0);
    check("rst_di0", ram_di0, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("en_after_rst", 32'(ram_en0), 32'(1 - GATED_BUILD));

    do_write(32'h0, 32'hAA0055BB, 4'hF, "wr0");
    do_read(32'h0, "rd0");
    do_write(32'h4, 32'hAA0055CC, 4'hF, "wr4");
    do_write(32'h4, 32'h00003300, 4'b0010, "wr4_b1");
    do_read(32'h4, "rd4");
    check("rd4_value", last_read, 32'hAA0033CC);
    do_write(32'h7FC, 32'hF0F055DD, 4'hF, "wr_top");
    do_read(32'h7FC, "rd_top");
    do_read(32'h0, "rd0_again");
    do_bad(32'h800, 1'b0, "oow_rd");
    do_bad(32'h0000_0800, 1'b1, "oow_wr");
    do_write(32'h1, 32'h12345678, 4'h0, "wr_nosel");
    do_read(32'h2, "rd0_nosel");

    // Master abandons a read during RD1.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h7FC;
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (wb_ack_o) acks++;
    end
    check("abort_rd1_ack", 32'(acks), 32'd0);
    check("abort_rd1_hold", wb_dat_o, last_read);
    wake_pending = 0;
    do_read(32'h4, "rd_after_abort");

    // Reset lands while the read sits in RD2.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("rd2rst_ack", 32'(wb_ack_o), 32'd0);
    check("rd2rst_dat", wb_dat_o, 32'd0);
    check("rd2rst_we0", 32'(ram_we0), 32'd0);
    check("rd2rst_en0", 32'(ram_en0), 32'd0);
    check("rd2rst_a0",  32'(ram_a0), 32'd0);
    check("rd2rst_di0", ram_di0, 32'd0);
    rst = 1'b0;
    last_read = '0;
    wake_pending = GATED_BUILD;
    do_read(32'h4, "rd_after_rst");

    repeat (20) @(posedge clk);
    @(negedge clk);
    check("idle20_en0", 32'(ram_en0), 32'(1 - GATED_BUILD));
    wake_pending = GATED_BUILD;
    do_read(32'h0, "rd_after_idle");

    for (int i = 0; i < 12; i++) do_write(pick_addr(i), $urandom, 4'hF, "fill");
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0: do_bad($urandom | 32'h800, 1'($urandom_range(0, 1)), "rnd_oow");
        1, 2, 3, 4: begin
          a = pick_addr(int'($urandom_range(0, 11))) | 32'($urandom_range(0, 3));
          do_write(a, $urandom, 4'($urandom_range(0, 15)), "rnd_wr");
        end
        default: begin
          a = pick_addr(int'($urandom_range(0, 11))) | 32'($urandom_range(0, 3));
          do_read(a, "rnd_rd");
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dffram_wb_adapter.md
# dffram_wb_adapter

Wishbone B4 classic slave that sits directly upstream of the DFFRAM512x32 macro and drives its CLK-domain port set (WE0, EN0, A0, Di0, Do0). Converts single-beat bus reads/writes with byte selects into registered RAM accesses, returns read data with a fixed latency, flags out-of-window addresses, and optionally gates EN0 when the bus is idle.

## Interface
- BANKS, 32, RAM banks of 16 words; RAM depth = 16*BANKS
- WSIZE, 4, bytes per word; byte-enable width
- AWIDTH, $clog2(BANKS)+4 (localparam, 9), RAM word-address width
- BASE_ADDR, 32'h0000_0000, byte base of the RAM window; aligned to 4*16*BANKS
- IDLE_CYCLES, 16, idle cycles before EN0 is gated (used only with DFFRAM_WB_PWRGATE_EN)

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  synchronous, active-high reset
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_sel_i  in  WSIZE  byte selects
- wb_adr_i  in  32  byte address
- wb_dat_i  in  8*WSIZE  write data
- wb_dat_o  out  8*WSIZE  read data, valid with ack
- wb_ack_o  out  1  one-cycle acknowledge
- wb_err_o  out  1  one-cycle error (out of window)
- ram_we0  out  WSIZE  to WE0
- ram_en0  out  1  to EN0
- ram_a0  out  AWIDTH  to A0
- ram_di0  out  8*WSIZE  to Di0
- ram_do0  in  8*WSIZE  from Do0

## Operation
- All RAM-side outputs registered; no combinational path bus->RAM.
- Request = wb_cyc_i & wb_stb_i sampled in IDLE. Word address = wb_adr_i[AWIDTH+1:2]; in window iff wb_adr_i[31:AWIDTH+2] == BASE_ADDR[31:AWIDTH+2]. wb_adr_i[1:0] ignored.
- FSM states: IDLE, WAKE (macro only), WR, RD1, RD2, ACK, ERR.
- IDLE + request out of window -> ERR: wb_err_o=1 one cycle, no RAM access, -> IDLE.
- IDLE + write in window -> load ram_a0, ram_di0=wb_dat_i, ram_we0=wb_sel_i -> WR (RAM samples at end of WR) -> ACK; ram_we0 cleared on leaving WR.
- IDLE + read in window -> load ram_a0, ram_we0=0 -> RD1 -> RD2 (capture ram_do0 into wb_dat_o at end of RD2) -> ACK.
- wb_sel_i=0 write: RAM cycle still issued with WE0=0, ack returned, memory unchanged.
- ACK: wb_ack_o=1 one cycle -> IDLE. Master must drop stb after ack; a held stb starts a new transaction from IDLE.
- wb_cyc_i deasserted in WR/RD1/RD2: RAM access completes, ack suppressed, -> IDLE.
- wb_dat_o holds last read value until next read capture.

## Timing
- Reset values: wb_dat_o=0, wb_ack_o=0, wb_err_o=0, ram_we0=0, ram_a0=0, ram_di0=0, ram_en0=0; state IDLE.
- Without gating: ram_en0=1 from first cycle after RST deasserts.
- Write: request sampled at edge N, ack high in cycle N+2. Read: ack and data in cycle N+3. Error: err in cycle N+1.
- Back-to-back: next request accepted no earlier than cycle after ack (max 1 txn / 3 cycles write, 4 read).
- RST during WR: bus sees no ack; target word content undefined. RST during reads: no ack, RAM unaffected.

## Configuration
- DFFRAM_WB_PWRGATE_EN defined: counter of consecutive request-free IDLE cycles; at IDLE_CYCLES ram_en0 drops to 0. Request while gated -> WAKE (ram_en0=1, ram_we0=0, one cycle) -> normal access; adds +1 cycle latency. Any request clears counter. After reset, starts gated.
- Not defined: ram_en0 constantly 1 outside reset; no WAKE state, no counter.

## Structure
- Package dffram_wb_pkg: state enum, ADDR_LSB=2, window-compare helper function.
- Sub-module dffram_wb_pwrgate: idle counter + gated flag (instantiated only under DFFRAM_WB_PWRGATE_EN).

## Test plan
- Write 0xAA0055BB sel 4'b1111 to byte addr 0x0, read 0x0 -> wb_dat_o=0xAA0055BB, ack at N+3, ram_we0 high exactly one cycle.
- Fill 0x4 with 0xAA0055CC, write 0x00003300 sel 4'b0010 -> readback 0xAA0033CC.
- Write/read top word byte addr 0x7FC (word 0x1FF) 0xF0F055DD -> readback matches; word 0x000 unchanged.
- Access byte addr 0x800 -> wb_err_o one cycle at N+1, no ram_en0/ram_we0 activity change, no ack.
- Drop wb_cyc_i in RD1 -> no ack; next read returns correct data. Assert RST in RD2 -> all outputs 0 next cycle.
- With DFFRAM_WB_PWRGATE_EN, IDLE_CYCLES=16: idle 20 cycles -> ram_en0=0; read 0x0 -> WAKE seen, ack at N+4, correct data.
